// File: rtl/hack_data_memory.sv
// hack_data_memory: data-memory responder for the Hack CPU.
//
// Serves the CPU's data accesses with a combinational read port. It holds the
// general RAM, the screen buffer, a keyboard FIFO and a free-running timer.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   addrM, outM, writeM CPU data address (bit 15 ignored), write data, write strobe
//   inM                 read data for addrM, combinational
//   scr_raddr/scr_rdata display-controller screen read port, 1-cycle latency
//   key_valid/key_data  keyboard word source
//   key_ready           FIFO can accept a word (not full)
//
// Address map (a = addrM[14:0]):
//   0x0000-0x3FFF  RAM (words at a >= RAM_WORDS read 0, writes ignored)
//   0x4000-0x5FFF  screen buffer
//   0x6000         KBD: FIFO head (0 if empty); any write pops one entry
//   0x6001         TIMER: count; a write loads the count and clears the prescaler
//   0x6002         STATUS: bit0 non-empty, bit1 full, [7:4] entry count (max 15)
module hack_data_memory #(
    parameter int RAM_WORDS      = 16384,
    parameter int KEY_FIFO_DEPTH = 4,
    parameter int TIMER_DIV      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addrM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [12:0] scr_raddr,
    output logic [15:0] scr_rdata,
    input  logic        key_valid,
    input  logic [15:0] key_data,
    output logic        key_ready
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = $clog2(KEY_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PRE_W  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [15:0] ram [RAM_WORDS];
    logic [15:0] scr [8192];
    logic [15:0] fifo_mem [KEY_FIFO_DEPTH];

    logic [14:0]      a;
    logic             unused_addr_msb;
    logic             sel_ram, sel_scr, sel_kbd, sel_tmr, sel_sts;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, push, pop;
    logic [4:0]       count_ext;
    logic [3:0]       count_sat;
    logic [15:0]      tcount;
    logic [PRE_W-1:0] presc;
    logic             pre_wrap;

    assign a               = addrM[14:0];
    assign unused_addr_msb = addrM[15];

    // RAM_WORDS never exceeds 16384, so this compare also bounds the RAM window.
    assign sel_ram = (a < 15'(RAM_WORDS));
    assign sel_scr = (a[14:13] == 2'b10);
    assign sel_kbd = (a == 15'h6000);
    assign sel_tmr = (a == 15'h6001);
    assign sel_sts = (a == 15'h6002);

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(KEY_FIFO_DEPTH));
    assign key_ready = !full;
    assign push      = key_valid && key_ready;
    assign pop       = writeM && sel_kbd && !empty;

    // A depth-16 FIFO can hold 16 entries, but STATUS only has a 4-bit field.
    assign count_ext = 5'(count);
    assign count_sat = count_ext[4] ? 4'hF : count_ext[3:0];

    assign pre_wrap = (presc == PRE_W'(TIMER_DIV - 1));

    // Storage arrays are never cleared; reset only suppresses writes on its edge.
    always_ff @(posedge clk) begin
        if (!reset && writeM && sel_ram) ram[a[RAM_AW-1:0]] <= outM;
        if (!reset && writeM && sel_scr) scr[a[12:0]] <= outM;
        if (!reset && push)              fifo_mem[wr_ptr] <= key_data;
    end

    // Nonblocking read of scr gives read-before-write against a same-cycle CPU write.
    always_ff @(posedge clk) begin
        if (reset) scr_rdata <= '0;
        else       scr_rdata <= scr[scr_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcount <= '0;
            presc  <= '0;
        end else if (writeM && sel_tmr) begin
            tcount <= outM;
            presc  <= '0;
        end else if (pre_wrap) begin
            tcount <= tcount + 16'd1;
            presc  <= '0;
        end else begin
            presc  <= presc + PRE_W'(1);
        end
    end

    always_comb begin
        inM = '0;
        if (sel_ram)      inM = ram[a[RAM_AW-1:0]];
        else if (sel_scr) inM = scr[a[12:0]];
        else if (sel_kbd) inM = empty ? 16'h0000 : fifo_mem[rd_ptr];
        else if (sel_tmr) inM = tcount;
        else if (sel_sts) inM = {8'h00, count_sat, 2'b00, full, !empty};
    end

endmodule

// File: tb/tb_hack_data_memory.sv
// Testbench for hack_data_memory. Two instances share all inputs:
// dut uses default parameters, dut2 uses RAM_WORDS=1024 and TIMER_DIV=3.
module tb_hack_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addrM, outM;
    logic        writeM;
    logic [12:0] scr_raddr;
    logic        key_valid;
    logic [15:0] key_data;
    logic [15:0] inM, inM2, scr_rdata, scr_rdata2;
    logic        key_ready, key_ready2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        int          src;
        logic [15:0] exp;
    } exp_t;
    exp_t sbq[$];

    localparam int S_INM = 0, S_INM2 = 1, S_SCR = 2, S_RDY = 3;

    always #5 clk = ~clk;

    hack_data_memory dut (
        .clk(clk), .reset(reset), .addrM(addrM), .outM(outM), .writeM(writeM),
        .inM(inM), .scr_raddr(scr_raddr), .scr_rdata(scr_rdata),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready)
    );

    hack_data_memory #(.RAM_WORDS(1024), .KEY_FIFO_DEPTH(4), .TIMER_DIV(3)) dut2 (
        .clk(clk), .reset(reset), .addrM(addrM), .outM(outM), .writeM(writeM),
        .inM(inM2), .scr_raddr(scr_raddr), .scr_rdata(scr_rdata2),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready2)
    );

    task automatic expect_val(input string tag, input int src, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [15:0] observe(input int src);
        case (src)
            S_INM:   return inM;
            S_INM2:  return inM2;
            S_SCR:   return scr_rdata;
            default: return {15'h0, key_ready};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        logic [15:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = observe(e.src);
            checks++;
            assert (obs === e.exp) begin
                passes++;
            end else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic cpu(input logic [15:0] addr, input logic [15:0] data, input logic wr);
        addrM  = addr;
        outM   = data;
        writeM = wr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu(16'h0000, 16'h0000, 1'b0);
        scr_raddr = '0;
        key_valid = 1'b0;
        key_data  = '0;
        tick();
        tick();

        // Reset state while reset is still asserted
        cpu(16'h6001, 16'h0000, 1'b0);
        expect_val("rst_timer", S_INM, 16'h0000);
        expect_val("rst_timer2", S_INM2, 16'h0000);
        expect_val("rst_scr", S_SCR, 16'h0000);
        expect_val("rst_ready", S_RDY, 16'h0001);
        sample();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("rst_kbd", S_INM, 16'h0000);
        settle();
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("rst_status", S_INM, 16'h0000);
        settle();
        tick();

        // Timer counting from reset: DIV=1 and DIV=3
        reset = 1'b0;
        cpu(16'h6001, 16'h0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            expect_val($sformatf("tmr_div1_%0d", i), S_INM, 16'(i));
            expect_val($sformatf("tmr_div3_%0d", i), S_INM2, 16'(i / 3));
            sample();
            tick();
        end

        // Timer load and wrap
        cpu(16'h6001, 16'hFFFE, 1'b1);
        tick();
        cpu(16'h6001, 16'h0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            expect_val($sformatf("tmr_wrap1_%0d", i), S_INM, 16'hFFFE + 16'(i));
            expect_val($sformatf("tmr_wrap3_%0d", i), S_INM2, (i < 3) ? 16'hFFFE : (i < 6) ? 16'hFFFF : 16'h0000);
            sample();
            tick();
        end

        // Load beats increment on same edge; prescaler cleared
        cpu(16'h6001, 16'h1234, 1'b1);
        tick();
        cpu(16'h6001, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_val($sformatf("tmr_load1_%0d", i), S_INM, 16'h1234 + 16'(i));
            expect_val($sformatf("tmr_load3_%0d", i), S_INM2, (i < 3) ? 16'h1234 : 16'h1235);
            sample();
            tick();
        end

        // RAM write/read at 0x0010
        cpu(16'h0010, 16'h0000, 1'b1);
        tick();
        cpu(16'h0010, 16'h1234, 1'b1);
        expect_val("ram10_old", S_INM, 16'h0000);
        sample();
        tick();
        cpu(16'h0010, 16'h0000, 1'b0);
        expect_val("ram10_new", S_INM, 16'h1234);
        expect_val("ram10_new2", S_INM2, 16'h1234);
        sample();
        cpu(16'h8010, 16'h0000, 1'b0);
        expect_val("ram10_bit15", S_INM, 16'h1234);
        settle();

        // Top of RAM and beyond RAM_WORDS on the smaller instance
        cpu(16'h3FFF, 16'h0000, 1'b1);
        tick();
        cpu(16'h3FFF, 16'h5A5A, 1'b1);
        expect_val("ram3fff_old", S_INM, 16'h0000);
        sample();
        tick();
        cpu(16'h3FFF, 16'h0000, 1'b0);
        expect_val("ram3fff_new", S_INM, 16'h5A5A);
        expect_val("ram3fff_small", S_INM2, 16'h0000);
        sample();
        cpu(16'h0400, 16'h7777, 1'b1);
        tick();
        cpu(16'h0400, 16'h0000, 1'b0);
        expect_val("ram400_big", S_INM, 16'h7777);
        expect_val("ram400_small", S_INM2, 16'h0000);
        sample();

        // Screen port read-before-write
        cpu(16'h4005, 16'h1111, 1'b1);
        tick();
        scr_raddr = 13'd5;
        cpu(16'h4005, 16'hAAAA, 1'b1);
        tick();
        cpu(16'h4005, 16'h0000, 1'b0);
        expect_val("scr_old", S_SCR, 16'h1111);
        expect_val("scr_cpu", S_INM, 16'hAAAA);
        sample();
        tick();
        expect_val("scr_new", S_SCR, 16'hAAAA);
        sample();

        // FIFO fill, including a word offered while full
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("fifo_ready_empty", S_RDY, 16'h0001);
        sample();
        key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_data = 16'h0041 + 16'(i);
            tick();
        end
        key_valid = 1'b0;
        expect_val("fifo_full_status", S_INM, 16'h0043);
        expect_val("fifo_full_ready", S_RDY, 16'h0000);
        sample();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("fifo_head0", S_INM, 16'h0041);
        settle();

        // Drain, then pop on empty
        for (int j = 0; j < 4; j++) begin
            cpu(16'h6000, 16'hFFFF, 1'b1);
            tick();
            cpu(16'h6000, 16'h0000, 1'b0);
            expect_val($sformatf("fifo_drain_%0d", j), S_INM, (j < 3) ? 16'h0042 + 16'(j) : 16'h0000);
            expect_val($sformatf("fifo_drain_rdy_%0d", j), S_RDY, 16'h0001);
            sample();
        end
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("fifo_empty_status", S_INM, 16'h0000);
        settle();
        cpu(16'h6000, 16'h0000, 1'b1);
        tick();
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("fifo_pop_empty_status", S_INM, 16'h0000);
        expect_val("fifo_pop_empty_rdy", S_RDY, 16'h0001);
        sample();

        // Simultaneous push and pop at count 2
        key_valid = 1'b1;
        key_data  = 16'h0050;
        tick();
        key_data  = 16'h0051;
        tick();
        key_data  = 16'h0052;
        cpu(16'h6000, 16'h0000, 1'b1);
        tick();
        key_valid = 1'b0;
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("pushpop_status", S_INM, 16'h0021);
        sample();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("pushpop_head", S_INM, 16'h0051);
        settle();
        cpu(16'h6000, 16'h0000, 1'b1);
        tick();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("pushpop_last", S_INM, 16'h0052);
        sample();
        cpu(16'h6000, 16'h0000, 1'b1);
        tick();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("pushpop_empty", S_INM, 16'h0000);
        sample();

        // Pointer wrap: cycle 10 words through
        for (int i = 0; i < 10; i++) begin
            key_valid = 1'b1;
            key_data  = 16'h0060 + 16'(i);
            tick();
            key_valid = 1'b0;
            cpu(16'h6000, 16'h0000, 1'b0);
            expect_val($sformatf("wrap_%0d", i), S_INM, 16'h0060 + 16'(i));
            sample();
            cpu(16'h6000, 16'h0000, 1'b1);
            tick();
            cpu(16'h6000, 16'h0000, 1'b0);
        end

        // Reset mid-operation
        key_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_data = 16'h0070 + 16'(i);
            tick();
        end
        key_valid = 1'b0;
        cpu(16'h0020, 16'hBEEF, 1'b1);
        tick();
        cpu(16'h6001, 16'h0500, 1'b1);
        tick();
        cpu(16'h6001, 16'h0000, 1'b0);
        expect_val("pre_rst_timer", S_INM, 16'h0500);
        expect_val("pre_rst_scr", S_SCR, 16'hAAAA);
        sample();
        reset     = 1'b1;
        key_valid = 1'b1;
        key_data  = 16'h0099;
        cpu(16'h0020, 16'hDEAD, 1'b1);
        tick();
        reset     = 1'b0;
        key_valid = 1'b0;
        cpu(16'h6001, 16'h0000, 1'b0);
        expect_val("mid_rst_timer", S_INM, 16'h0000);
        expect_val("mid_rst_timer2", S_INM2, 16'h0000);
        expect_val("mid_rst_scr", S_SCR, 16'h0000);
        expect_val("mid_rst_ready", S_RDY, 16'h0001);
        sample();
        cpu(16'h0020, 16'h0000, 1'b0);
        expect_val("mid_rst_ram", S_INM, 16'hBEEF);
        settle();
        cpu(16'h6002, 16'h0000, 1'b0);
        expect_val("mid_rst_status", S_INM, 16'h0000);
        settle();
        cpu(16'h6000, 16'h0000, 1'b0);
        expect_val("mid_rst_kbd", S_INM, 16'h0000);
        settle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory responder for the Hack CPU. It serves the CPU's addrM/outM/writeM accesses and returns the read word on inM in the same cycle.
- Contains general RAM, a screen buffer with a registered read port for the display controller, a keyboard FIFO with a valid/ready input, and a free-running timer.
- Sits beside the CPU at the top level; the instruction ROM is not part of this block.

Parameters:
- RAM_WORDS, 16384: implemented general RAM words, 1..16384.
- KEY_FIFO_DEPTH, 4: keyboard FIFO entries; power of 2, 2..16.
- TIMER_DIV, 1: clock cycles per timer increment, ≥1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- addrM  in  16  CPU data address (bit 15 ignored)
- outM  in  16  CPU write data
- writeM  in  1  CPU write strobe
- inM  out  16  read data for addrM, combinational
- scr_raddr  in  13  display-controller screen word address
- scr_rdata  out  16  screen word, registered
- key_valid  in  1  keyboard source has a word
- key_data  in  16  keyboard word
- key_ready  out  1  FIFO can accept (= not full)

Behaviour:
- Address map uses a = addrM[14:0]:
  - 0x0000-0x3FFF: RAM. Words at a ≥ RAM_WORDS read 0; writes to them are ignored.
  - 0x4000-0x5FFF: screen buffer, 8192 words, index a-0x4000.
  - 0x6000 KBD: read returns the FIFO head, or 0 if empty. Any write pops one entry; the data written is ignored.
  - 0x6001 TIMER: read returns the count. A write loads outM into the count and clears the prescaler.
  - 0x6002 STATUS (read-only): bit0 = non-empty, bit1 = full, bits[7:4] = entry count saturated at 15, other bits 0.
  - All other addresses read 0; writes to them are ignored.
- Reads are asynchronous: inM follows addrM and the current storage contents with no clock.
- Writes take effect on the clk edge where writeM=1.
  - During the write cycle inM shows the old content; the new value is visible after that edge.
- scr_rdata is registered with 1-cycle latency.
  - If the CPU writes the same screen word in the same cycle, scr_rdata returns the old word (read-before-write).
- Keyboard FIFO:
  - Push when key_valid && key_ready. key_ready = (count != KEY_FIFO_DEPTH).
  - Pop happens on a write to 0x6000 while count > 0. A pop on an empty FIFO is a no-op.
  - Push and pop in the same cycle: count is unchanged, the head advances, and the new word is appended.
    - This is legal when full, because key_ready is low when full, so no push can occur.
  - Read/write pointers wrap modulo KEY_FIFO_DEPTH.
  - key_data must be held while key_valid && !key_ready. The block never drops a word.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1; the count increments when the prescaler wraps.
  - The count wraps 0xFFFF→0x0000.
  - With TIMER_DIV=1 the count increments every cycle.
  - A write to 0x6001 has priority over the increment on that edge.
- Reset (synchronous, priority over everything on that edge):
  - FIFO emptied (key_ready=1, KBD reads 0).
  - Timer count and prescaler = 0.
  - scr_rdata = 0.
  - RAM and screen contents are not cleared.
  - A writeM during the reset cycle is discarded.
  - A FIFO push during the reset cycle is discarded.

Test Plan:
- RAM write/read: write 0x1234 to 0x0010, then hold addrM=0x0010 → inM=0x0000 (old) during the write cycle and 0x1234 after the edge. Address 0x3FFF with RAM_WORDS=16384 behaves the same. With RAM_WORDS=1024, a write to 0x0400 leaves inM=0 there.
- Screen port: CPU writes 0xAAAA to 0x4005; scr_raddr=5 in that same cycle → scr_rdata shows the old word next cycle. Repeat the read → scr_rdata=0xAAAA.
- FIFO fill/drain (DEPTH=4): push 0x41,0x42,0x43,0x44 → key_ready=0, STATUS=0x0043, KBD=0x41. Write 0x6000 → KBD=0x42, key_ready=1. Pop 3 more → KBD=0, STATUS=0. One more pop → no change.
- Simultaneous push/pop at count=2: count stays 2, KBD advances to the next entry, and the new word arrives last. Verify pointer wrap by cycling 10 words through the FIFO in order.
- Timer (TIMER_DIV=3): after reset, the count reads 0,0,0,1,1,1,2. Write 0xFFFE → wraps to 0x0000 six cycles later. Write and increment on the same edge → the loaded value wins.
- Reset mid-operation: with 3 FIFO entries, timer=0x0500 and writeM=1 to 0x0020, assert reset for one cycle → FIFO empty, timer=0, scr_rdata=0, and RAM[0x0020] keeps its prior value.
